// File: rtl/id_ex_register_if.sv
// Decode-to-execute pipeline bundle: decode-side inputs, writeback bypass
// port, registered execute-side outputs and the load-use stall request.
interface id_ex_register_if;
    // Decode-stage request and control
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  rd_D;
    logic [31:0] imm_D;
    logic [31:0] pc_D;
    logic        RegWrite_D;
    logic        MemWrite_D;
    logic        MemRead_D;
    logic        ALUSrc_D;
    logic        Branch_D;
    logic [2:0]  ALUControl_D;
    // Register-file write port, seen here for same-edge bypass
    logic        WE3_W;
    logic [4:0]  A3_W;
    logic [31:0] WD3_W;
    // Execute-stage registered outputs
    logic        valid_E;
    logic [31:0] RS1_E;
    logic [31:0] RS2_E;
    logic [4:0]  A1_E;
    logic [4:0]  A2_E;
    logic [4:0]  rd_E;
    logic [31:0] imm_E;
    logic [31:0] pc_E;
    logic        RegWrite_E;
    logic        MemWrite_E;
    logic        MemRead_E;
    logic        ALUSrc_E;
    logic        Branch_E;
    logic [2:0]  ALUControl_E;
    logic        hazard_stall;
    logic [15:0] bubble_cnt;

    modport master (
        output stall, flush, id_valid, RD1, RD2, A1, A2, rd_D, imm_D, pc_D,
               RegWrite_D, MemWrite_D, MemRead_D, ALUSrc_D, Branch_D,
               ALUControl_D, WE3_W, A3_W, WD3_W,
        input  valid_E, RS1_E, RS2_E, A1_E, A2_E, rd_E, imm_E, pc_E,
               RegWrite_E, MemWrite_E, MemRead_E, ALUSrc_E, Branch_E,
               ALUControl_E, hazard_stall, bubble_cnt
    );

    modport slave (
        input  stall, flush, id_valid, RD1, RD2, A1, A2, rd_D, imm_D, pc_D,
               RegWrite_D, MemWrite_D, MemRead_D, ALUSrc_D, Branch_D,
               ALUControl_D, WE3_W, A3_W, WD3_W,
        output valid_E, RS1_E, RS2_E, A1_E, A2_E, rd_E, imm_E, pc_E,
               RegWrite_E, MemWrite_E, MemRead_E, ALUSrc_E, Branch_E,
               ALUControl_E, hazard_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with writeback bypass of source operands,
// load-use hazard detection, bubble insertion and a saturating bubble count.
module id_ex_register (
    input logic               clk,
    input logic               rst,
    id_ex_register_if.slave   bus
);

    // Operand select: x0 always reads zero; a same-edge register-file write
    // to the source register wins over the stale read data.
    function automatic logic [31:0] f_bypass(
        input logic [4:0]  a,
        input logic [31:0] rd,
        input logic        we,
        input logic [4:0]  a3,
        input logic [31:0] wd
    );
        if (a == 5'd0)
            return 32'd0;
        else if (we && (a3 != 5'd0) && (a3 == a))
            return wd;
        else
            return rd;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] f_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic        r_valid;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_a1;
    logic [4:0]  r_a2;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic        r_regwrite;
    logic        r_memwrite;
    logic        r_memread;
    logic        r_alusrc;
    logic        r_branch;
    logic [2:0]  r_aluctrl;
    logic [15:0] r_bubble_cnt;

    logic        w_hazard;
    logic        w_bubble;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;

    // Load-use detection against the instruction currently in execute
    always_comb begin
        w_hazard = r_valid && r_memread && (r_rd != 5'd0) && bus.id_valid &&
                   ((r_rd == bus.A1) || (r_rd == bus.A2));
        w_bubble = bus.flush || w_hazard;
        w_rs1    = f_bypass(bus.A1, bus.RD1, bus.WE3_W, bus.A3_W, bus.WD3_W);
        w_rs2    = f_bypass(bus.A2, bus.RD2, bus.WE3_W, bus.A3_W, bus.WD3_W);
    end

    // Pipeline register: stall holds, flush/hazard bubbles, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_a1         <= 5'd0;
            r_a2         <= 5'd0;
            r_rd         <= 5'd0;
            r_imm        <= 32'd0;
            r_pc         <= 32'd0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alusrc     <= 1'b0;
            r_branch     <= 1'b0;
            r_aluctrl    <= 3'd0;
            r_bubble_cnt <= 16'd0;
        end else if (bus.stall) begin
            // hold everything; a concurrent flush is dropped
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_a1         <= 5'd0;
            r_a2         <= 5'd0;
            r_rd         <= 5'd0;
            r_imm        <= 32'd0;
            r_pc         <= 32'd0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alusrc     <= 1'b0;
            r_branch     <= 1'b0;
            r_aluctrl    <= 3'd0;
            r_bubble_cnt <= f_sat_inc(r_bubble_cnt);
        end else begin
            // an invalid decode slot carries its data but no side effects
            r_valid      <= bus.id_valid;
            r_rs1        <= w_rs1;
            r_rs2        <= w_rs2;
            r_a1         <= bus.A1;
            r_a2         <= bus.A2;
            r_rd         <= bus.rd_D;
            r_imm        <= bus.imm_D;
            r_pc         <= bus.pc_D;
            r_regwrite   <= bus.id_valid && bus.RegWrite_D;
            r_memwrite   <= bus.id_valid && bus.MemWrite_D;
            r_memread    <= bus.id_valid && bus.MemRead_D;
            r_alusrc     <= bus.id_valid && bus.ALUSrc_D;
            r_branch     <= bus.id_valid && bus.Branch_D;
            r_aluctrl    <= bus.id_valid ? bus.ALUControl_D : 3'd0;
        end
    end

    // Drive the execute-side outputs from the pipeline register
    always_comb begin
        bus.valid_E      = r_valid;
        bus.RS1_E        = r_rs1;
        bus.RS2_E        = r_rs2;
        bus.A1_E         = r_a1;
        bus.A2_E         = r_a2;
        bus.rd_E         = r_rd;
        bus.imm_E        = r_imm;
        bus.pc_E         = r_pc;
        bus.RegWrite_E   = r_regwrite;
        bus.MemWrite_E   = r_memwrite;
        bus.MemRead_E    = r_memread;
        bus.ALUSrc_E     = r_alusrc;
        bus.Branch_E     = r_branch;
        bus.ALUControl_E = r_aluctrl;
        bus.hazard_stall = w_hazard;
        bus.bubble_cnt   = r_bubble_cnt;
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register with a behavioural
// model of the execute-stage contents and the bubble counter.
module tb_id_ex_register;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_register_if bus ();

    id_ex_register dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  a1, a2, rd;
        logic        rw, mw, mr, as, br;
        logic [2:0]  alu;
    } e_t;

    e_t          m;
    int unsigned m_cnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    function automatic logic exp_hazard();
        return m.valid && m.mr && (m.rd != 5'd0) && bus.id_valid &&
               (m.rd == bus.A1 || m.rd == bus.A2);
    endfunction

    function automatic logic [31:0] exp_opnd(input logic [4:0] a, input logic [31:0] rd);
        if (a == 5'd0) return 32'd0;
        if (bus.WE3_W && bus.A3_W == a) return bus.WD3_W;
        return rd;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_cnt = 0;
    endtask

    task automatic model_edge();
        logic hz;
        e_t   n;
        hz = exp_hazard();
        if (bus.stall) return;
        if (bus.flush || hz) begin
            m = '{default: '0};
            if (m_cnt < 65535) m_cnt++;
        end else begin
            n.valid = bus.id_valid;
            n.rs1   = exp_opnd(bus.A1, bus.RD1);
            n.rs2   = exp_opnd(bus.A2, bus.RD2);
            n.a1    = bus.A1;
            n.a2    = bus.A2;
            n.rd    = bus.rd_D;
            n.imm   = bus.imm_D;
            n.pc    = bus.pc_D;
            n.rw    = bus.id_valid & bus.RegWrite_D;
            n.mw    = bus.id_valid & bus.MemWrite_D;
            n.mr    = bus.id_valid & bus.MemRead_D;
            n.as    = bus.id_valid & bus.ALUSrc_D;
            n.br    = bus.id_valid & bus.Branch_D;
            n.alu   = bus.id_valid ? bus.ALUControl_D : 3'd0;
            m = n;
        end
    endtask

    task automatic check_e(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid_E),      32'(m.valid));
        chk({tag, ".rs1"},   bus.RS1_E,             m.rs1);
        chk({tag, ".rs2"},   bus.RS2_E,             m.rs2);
        chk({tag, ".a1"},    32'(bus.A1_E),         32'(m.a1));
        chk({tag, ".a2"},    32'(bus.A2_E),         32'(m.a2));
        chk({tag, ".rd"},    32'(bus.rd_E),         32'(m.rd));
        chk({tag, ".imm"},   bus.imm_E,             m.imm);
        chk({tag, ".pc"},    bus.pc_E,              m.pc);
        chk({tag, ".ctl"},   32'({bus.RegWrite_E, bus.MemWrite_E, bus.MemRead_E,
                                  bus.ALUSrc_E, bus.Branch_E, bus.ALUControl_E}),
                             32'({m.rw, m.mw, m.mr, m.as, m.br, m.alu}));
        chk({tag, ".cnt"},   32'(bus.bubble_cnt),   m_cnt);
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.RD1 = 0; bus.RD2 = 0; bus.A1 = 0; bus.A2 = 0; bus.rd_D = 0;
        bus.imm_D = 0; bus.pc_D = 0;
        bus.RegWrite_D = 0; bus.MemWrite_D = 0; bus.MemRead_D = 0;
        bus.ALUSrc_D = 0; bus.Branch_D = 0; bus.ALUControl_D = 0;
        bus.WE3_W = 0; bus.A3_W = 0; bus.WD3_W = 0;
    endtask

    task automatic rand_inputs();
        bus.stall        = ($urandom_range(0, 7) == 0);
        bus.flush        = ($urandom_range(0, 7) == 0);
        bus.id_valid     = ($urandom_range(0, 7) != 0);
        bus.RD1          = $urandom;
        bus.RD2          = $urandom;
        bus.A1           = 5'($urandom_range(0, 7));
        bus.A2           = 5'($urandom_range(0, 7));
        bus.rd_D         = 5'($urandom_range(0, 7));
        bus.imm_D        = $urandom;
        bus.pc_D         = $urandom;
        bus.RegWrite_D   = 1'($urandom);
        bus.MemWrite_D   = 1'($urandom);
        bus.MemRead_D    = 1'($urandom);
        bus.ALUSrc_D     = 1'($urandom);
        bus.Branch_D     = 1'($urandom);
        bus.ALUControl_D = 3'($urandom);
        bus.WE3_W        = 1'($urandom);
        bus.A3_W         = 5'($urandom_range(0, 7));
        bus.WD3_W        = $urandom;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input string tag, input bit full);
        #1;
        chk({tag, ".hz"}, 32'(bus.hazard_stall), 32'(exp_hazard()));
        @(posedge clk);
        model_edge();
        #1;
        if (full) check_e(tag);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_e("rst_async");
        chk("rst_async.hz", 32'(bus.hazard_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // plain load
        clear_inputs();
        bus.id_valid = 1; bus.A1 = 1; bus.RD1 = 32'hA5A5A5A5;
        bus.A2 = 2; bus.RD2 = 32'h12345678; bus.rd_D = 3; bus.pc_D = 32'h100;
        tick("load", 1);
        chk("load.rs1_lit", bus.RS1_E, 32'hA5A5A5A5);
        chk("load.rs2_lit", bus.RS2_E, 32'h12345678);

        // bypass, then x0 with a write to x0
        @(negedge clk);
        clear_inputs();
        bus.id_valid = 1; bus.A1 = 1; bus.RD1 = 0;
        bus.WE3_W = 1; bus.A3_W = 1; bus.WD3_W = 32'hDEADBEEF;
        tick("bypass", 1);
        chk("bypass.lit", bus.RS1_E, 32'hDEADBEEF);
        @(negedge clk);
        bus.A1 = 0; bus.RD1 = 32'h11111111; bus.A3_W = 0; bus.WD3_W = 32'hFFFFFFFF;
        tick("x0", 1);
        chk("x0.lit", bus.RS1_E, 32'd0);

        // load-use: a load to x5 followed by a consumer of x5
        @(negedge clk);
        clear_inputs();
        bus.id_valid = 1; bus.MemRead_D = 1; bus.RegWrite_D = 1; bus.rd_D = 5;
        tick("ld5", 1);
        @(negedge clk);
        clear_inputs();
        bus.id_valid = 1; bus.A2 = 5; bus.MemWrite_D = 1;
        #1 chk("lu.hz_lit", 32'(bus.hazard_stall), 32'd1);
        tick("lu", 1);
        chk("lu.valid_lit", 32'(bus.valid_E), 32'd0);
        chk("lu.cnt_lit", 32'(bus.bubble_cnt), 32'd1);

        // stall outranks flush; then flush alone
        @(negedge clk);
        clear_inputs();
        bus.id_valid = 1; bus.rd_D = 7; bus.RegWrite_D = 1; bus.pc_D = 32'h200;
        tick("pre_st", 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.stall = 1; bus.flush = 1; bus.pc_D = 32'h300 + i;
            tick("stflush", 1);
        end
        chk("stflush.pc_lit", bus.pc_E, 32'h200);
        @(negedge clk);
        bus.stall = 0; bus.flush = 1;
        tick("flush", 1);
        chk("flush.cnt_lit", 32'(bus.bubble_cnt), 32'd2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rand_inputs();
            tick("rnd", 1);
        end

        // async reset mid-cycle with a live load in execute
        @(negedge clk);
        clear_inputs();
        bus.id_valid = 1; bus.RegWrite_D = 1; bus.MemRead_D = 1; bus.rd_D = 3;
        tick("pre_rst", 1);
        @(negedge clk);
        bus.A1 = 3;
        #1 chk("pre_rst.hz_lit", 32'(bus.hazard_stall), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check_e("rst_mid");
        chk("rst_mid.hz", 32'(bus.hazard_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        bus.id_valid = 1; bus.A1 = 4; bus.RD1 = 32'hCAFE0001; bus.RegWrite_D = 1;
        tick("post_rst", 1);

        // saturation of the bubble counter
        @(negedge clk);
        clear_inputs();
        bus.flush = 1;
        while (m_cnt < 32'hFFFE) begin
            @(posedge clk);
            model_edge();
        end
        #1 chk("sat.pre", 32'(bus.bubble_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick("sat", 1);
        end
        chk("sat.lit", 32'(bus.bubble_cnt), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
